// File: rtl/mac_rx_deframer_pkg.sv
// Shared constants and types for the receive-side MAC deframer.
// Holds the XGMII character codes, the FSM state type and small lane helpers.
package mac_rx_deframer_pkg;

  localparam int unsigned N_CHANNELS = 4;
  localparam int unsigned W_BYTE     = 8;
  localparam int unsigned W_DATA     = N_CHANNELS * W_BYTE;
  localparam int unsigned W_RX_LEN   = 16;

  localparam logic [7:0] XGMII_START = 8'hFB;
  localparam logic [7:0] XGMII_TERM  = 8'hFD;
  localparam logic [7:0] XGMII_ERROR = 8'hFE;
  localparam logic [7:0] PREAMBLE    = 8'h55;
  localparam logic [7:0] SFD         = 8'hD5;

  typedef enum logic [1:0] {
    StIdle,
    StPre,
    StData,
    StDiscard
  } rx_state_e;

  typedef struct packed {
    logic [W_DATA-1:0]     data;
    logic [N_CHANNELS-1:0] keep;
    logic                  sof;
    logic                  eof;
    logic                  err;
    logic [W_RX_LEN-1:0]   len;
  } rx_word_t;

  // Byte counter add that sticks at all-ones instead of wrapping.
  function automatic logic [W_RX_LEN-1:0] len_add(logic [W_RX_LEN-1:0] cnt, logic [2:0] inc);
    logic [W_RX_LEN:0] sum;
    sum = {1'b0, cnt} + {{(W_RX_LEN - 2){1'b0}}, inc};
    return sum[W_RX_LEN] ? '1 : sum[W_RX_LEN-1:0];
  endfunction

  function automatic logic [N_CHANNELS-1:0] lanes_below(logic [2:0] k);
    logic [N_CHANNELS-1:0] mask;
    case (k)
      3'd0:    mask = 4'b0000;
      3'd1:    mask = 4'b0001;
      3'd2:    mask = 4'b0011;
      3'd3:    mask = 4'b0111;
      default: mask = 4'b1111;
    endcase
    return mask;
  endfunction

  function automatic logic [W_DATA-1:0] mask_data(logic [W_DATA-1:0] data,
                                                  logic [N_CHANNELS-1:0] keep);
    logic [W_DATA-1:0] res;
    for (int i = 0; i < int'(N_CHANNELS); i++) begin
      res[W_BYTE*i +: W_BYTE] = keep[i] ? data[W_BYTE*i +: W_BYTE] : '0;
    end
    return res;
  endfunction

endpackage

// File: rtl/mac_rx_term_detect.sv
// Finds the first control lane of a lane word and classifies it as /T/,
// and flags any /E/ anywhere in the word.
module mac_rx_term_detect
  import mac_rx_deframer_pkg::*;
(
  input  logic [N_CHANNELS-1:0] i_ctrl,
  input  logic [W_DATA-1:0]     i_data,
  output logic [2:0]            o_first_lane,
  output logic                  o_is_t,
  output logic                  o_is_e
);

  // Walk from the top lane down so the lowest control lane wins; 4 means none.
  always_comb begin
    o_first_lane = 3'd4;
    o_is_t       = 1'b0;
    o_is_e       = 1'b0;
    for (int i = int'(N_CHANNELS) - 1; i >= 0; i--) begin
      if (i_ctrl[i]) begin
        o_first_lane = 3'(i);
        o_is_t       = (i_data[W_BYTE*i +: W_BYTE] == XGMII_TERM);
        if (i_data[W_BYTE*i +: W_BYTE] == XGMII_ERROR) begin
          o_is_e = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/mac_rx_deframer.sv
// Receive deframer: strips /S/, preamble and SFD from XGMII lane words and
// emits payload+FCS words with keep, SOF/EOF, error and length.
module mac_rx_deframer
  import mac_rx_deframer_pkg::*;
#(
  parameter int unsigned MAX_FRAME = 1522,
  parameter int unsigned MIN_FRAME = 64
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_clk_en,
  input  logic                  i_clr,
  input  logic [N_CHANNELS-1:0] i_ctrl,
  input  logic [W_DATA-1:0]     i_data,
  output logic                  o_valid,
  output logic [W_DATA-1:0]     o_data,
  output logic [N_CHANNELS-1:0] o_keep,
  output logic                  o_sof,
  output logic                  o_eof,
  output logic                  o_err,
  output logic [W_RX_LEN-1:0]   o_len
);

  rx_state_e           state_q, state_d;
  logic [W_RX_LEN-1:0] cnt_q, cnt_d;
  logic                sof_arm_q, sof_arm_d;
  logic                hold_vld_q, hold_vld_d;
  rx_word_t            hold_q, hold_d;
  logic                out_vld_q, out_vld_d;
  rx_word_t            out_q, out_d;

  logic [2:0]          first_lane;
  logic                is_t;
  logic                is_e;
  logic                start_ok;
  logic                pre_ok;
  logic [W_RX_LEN-1:0] cnt_sum;
  logic                term_bad;

  mac_rx_term_detect u_term_detect (
    .i_ctrl       (i_ctrl),
    .i_data       (i_data),
    .o_first_lane (first_lane),
    .o_is_t       (is_t),
    .o_is_e       (is_e)
  );

  assign start_ok = (i_ctrl == 4'b0001) && (i_data == {PREAMBLE, PREAMBLE, PREAMBLE, XGMII_START});
  assign pre_ok   = (i_ctrl == 4'b0000) && (i_data == {SFD, PREAMBLE, PREAMBLE, PREAMBLE});

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    sof_arm_d  = sof_arm_q;
    hold_vld_d = hold_vld_q;
    hold_d     = hold_q;
    out_vld_d  = 1'b0;
    out_d      = '0;
    cnt_sum    = '0;
    term_bad   = 1'b0;

    // A held word already marked EOF has no successor to wait for.
    if (hold_vld_q && hold_q.eof) begin
      out_vld_d  = 1'b1;
      out_d      = hold_q;
      hold_vld_d = 1'b0;
    end

    unique case (state_q)
      StIdle: begin
        if (start_ok) begin
          state_d = StPre;
          cnt_d   = '0;
        end
      end
      StPre: begin
        if (pre_ok) begin
          state_d   = StData;
          sof_arm_d = 1'b1;
        end else begin
          state_d = StIdle;
        end
      end
      StData: begin
        if (i_ctrl == '0) begin
          cnt_sum   = len_add(cnt_q, 3'd4);
          cnt_d     = cnt_sum;
          sof_arm_d = 1'b0;
          if (hold_vld_q) begin
            out_vld_d = 1'b1;
            out_d     = hold_q;
          end
          hold_vld_d = 1'b1;
          hold_d     = '{data: i_data, keep: '1, sof: sof_arm_q, eof: 1'b0, err: 1'b0,
                         len: cnt_sum};
          if (32'(cnt_sum) > MAX_FRAME) begin
            hold_d.eof = 1'b1;
            hold_d.err = 1'b1;
            state_d    = StDiscard;
          end
        end else begin
          cnt_sum   = len_add(cnt_q, first_lane);
          cnt_d     = cnt_sum;
          term_bad  = !is_t || is_e || (32'(cnt_sum) < MIN_FRAME) ||
                      (32'(cnt_sum) > MAX_FRAME);
          sof_arm_d = 1'b0;
          state_d   = StIdle;
          if (first_lane == 3'd0) begin
            // Terminator in lane 0: EOF rides on the held word, or on an empty
            // word if the frame ended before any data arrived.
            out_vld_d  = 1'b1;
            out_d      = hold_vld_q ? hold_q : '0;
            if (!hold_vld_q) begin
              out_d.sof = sof_arm_q;
            end
            out_d.eof  = 1'b1;
            out_d.err  = term_bad;
            out_d.len  = cnt_sum;
            hold_vld_d = 1'b0;
          end else begin
            if (hold_vld_q) begin
              out_vld_d = 1'b1;
              out_d     = hold_q;
            end
            hold_vld_d = 1'b1;
            hold_d     = '{data: mask_data(i_data, lanes_below(first_lane)),
                           keep: lanes_below(first_lane), sof: sof_arm_q, eof: 1'b1,
                           err: term_bad, len: cnt_sum};
          end
        end
      end
      StDiscard: begin
        if (is_t || is_e) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset || i_clr) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      sof_arm_q  <= 1'b0;
      hold_vld_q <= 1'b0;
      hold_q     <= '0;
      out_vld_q  <= 1'b0;
      out_q      <= '0;
    end else if (i_clk_en) begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      sof_arm_q  <= sof_arm_d;
      hold_vld_q <= hold_vld_d;
      hold_q     <= hold_d;
      out_vld_q  <= out_vld_d;
      out_q      <= out_d;
    end
  end

  assign o_valid = out_vld_q;
  assign o_data  = out_q.data;
  assign o_keep  = out_q.keep;
  assign o_sof   = out_q.sof;
  assign o_eof   = out_q.eof;
  assign o_err   = out_q.err;
  assign o_len   = out_q.len;

endmodule

// File: tb/tb_mac_rx_deframer.sv
// Self-checking bench for mac_rx_deframer: frame table, hand sequences and
// random frames compared against a byte-level model of the expected stream.
module tb_mac_rx_deframer;

  localparam int MAX    = 1522;
  localparam int MIN    = 64;
  localparam int KIND_T = 0;  // clean /T/ termination
  localparam int KIND_E = 1;  // /E/ at the end position
  localparam int KIND_C = 2;  // other control character at the end position

  logic        clk = 1'b0;
  logic        i_reset, i_clk_en, i_clr;
  logic [3:0]  i_ctrl;
  logic [31:0] i_data;
  logic        o_valid, o_sof, o_eof, o_err;
  logic [31:0] o_data;
  logic [3:0]  o_keep;
  logic [15:0] o_len;

  always #5 clk = ~clk;

  mac_rx_deframer #(
    .MAX_FRAME (MAX),
    .MIN_FRAME (MIN)
  ) dut (
    .i_clk    (clk),
    .i_reset  (i_reset),
    .i_clk_en (i_clk_en),
    .i_clr    (i_clr),
    .i_ctrl   (i_ctrl),
    .i_data   (i_data),
    .o_valid  (o_valid),
    .o_data   (o_data),
    .o_keep   (o_keep),
    .o_sof    (o_sof),
    .o_eof    (o_eof),
    .o_err    (o_err),
    .o_len    (o_len)
  );

  typedef struct {
    logic [31:0] data;
    logic [3:0]  keep;
    bit          sof;
    bit          eof;
    bit          err;
    int          len;
  } word_t;

  typedef struct {
    int         len;
    int         kind;
    int         words;
    logic [3:0] keep;
    int         len_exp;
    bit         err;
  } vec_t;

  word_t        got_q[$];
  word_t        exp_q[$];
  byte unsigned pay_q[$];
  int           checks   = 0;
  int           failures = 0;
  bit           toggle   = 1'b0;
  vec_t         tbl[11];

  // The consumer takes a word on the enabled cycle it is presented.
  always @(negedge clk) begin
    if (!i_reset && o_valid && i_clk_en) begin
      got_q.push_back('{o_data, o_keep, o_sof, o_eof, o_err, int'(o_len)});
    end
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic step(input logic [3:0] c, input logic [31:0] d, input bit clr = 1'b0);
    if (toggle && $urandom_range(1, 0) == 1) begin
      @(posedge clk);
      #1;
      i_clk_en = 1'b0;
      i_clr    = 1'b0;
      i_ctrl   = 4'($urandom);
      i_data   = $urandom;
    end
    @(posedge clk);
    #1;
    i_clk_en = 1'b1;
    i_clr    = clr;
    i_ctrl   = c;
    i_data   = d;
  endtask

  task automatic idle_word();
    step(4'hF, 32'h07070707);
  endtask

  task automatic flush();
    repeat (4) idle_word();
  endtask

  function automatic logic [31:0] pay_word(input int w);
    return {pay_q[4*w+3], pay_q[4*w+2], pay_q[4*w+1], pay_q[4*w]};
  endfunction

  // Expected output words derived from the payload bytes and the end kind.
  task automatic model_frame(input int kind);
    int    l_bytes, n_bytes, nw;
    bit    bad;
    word_t w;
    l_bytes = pay_q.size();
    if (kind == KIND_T && l_bytes > MAX) begin
      n_bytes = (MAX / 4 + 1) * 4;
      bad     = 1'b1;
    end else begin
      n_bytes = l_bytes;
      bad     = (kind != KIND_T) || (l_bytes < MIN) || (l_bytes > MAX);
    end
    nw = (n_bytes + 3) / 4;
    if (nw == 0) nw = 1;
    for (int wi = 0; wi < nw; wi++) begin
      w.data = '0;
      w.keep = '0;
      for (int l = 0; l < 4; l++) begin
        if (4 * wi + l < n_bytes) begin
          w.data[8*l +: 8] = pay_q[4*wi+l];
          w.keep[l]        = 1'b1;
        end
      end
      w.sof = (wi == 0);
      w.eof = (wi == nw - 1);
      w.err = w.eof && bad;
      w.len = w.eof ? n_bytes : 0;
      exp_q.push_back(w);
    end
  endtask

  task automatic send_frame(input int len, input int kind, input int gap, input bit bad_sfd);
    int          full, k;
    logic [3:0]  c;
    logic [31:0] d;
    logic [7:0]  code;
    pay_q.delete();
    for (int i = 0; i < len; i++) pay_q.push_back(8'($urandom));
    step(4'b0001, 32'h555555FB);
    step(4'b0000, bad_sfd ? 32'hD4555555 : 32'hD5555555);
    full = len / 4;
    k    = len % 4;
    for (int w = 0; w < full; w++) step(4'b0000, pay_word(w));
    code = (kind == KIND_T) ? 8'hFD : (kind == KIND_E) ? 8'hFE : 8'h9C;
    c = '0;
    d = '0;
    for (int l = 0; l < 4; l++) begin
      if (l < k) begin
        d[8*l +: 8] = pay_q[4*full+l];
      end else begin
        c[l]        = 1'b1;
        d[8*l +: 8] = (l == k) ? code : 8'h07;
      end
    end
    step(c, d);
    repeat (gap) idle_word();
    if (!bad_sfd) model_frame(kind);
  endtask

  task automatic compare_streams(input string tag);
    logic [31:0] m;
    check($sformatf("%s word count", tag), got_q.size(), exp_q.size());
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      for (int l = 0; l < 4; l++) m[8*l +: 8] = {8{exp_q[i].keep[l]}};
      check($sformatf("%s data[%0d]", tag, i), int'(got_q[i].data & m), int'(exp_q[i].data & m));
      check($sformatf("%s keep[%0d]", tag, i), int'(got_q[i].keep), int'(exp_q[i].keep));
      check($sformatf("%s sof[%0d]", tag, i), int'(got_q[i].sof), int'(exp_q[i].sof));
      check($sformatf("%s eof[%0d]", tag, i), int'(got_q[i].eof), int'(exp_q[i].eof));
      check($sformatf("%s err[%0d]", tag, i), int'(got_q[i].err), int'(exp_q[i].err));
      if (exp_q[i].eof) begin
        check($sformatf("%s len[%0d]", tag, i), got_q[i].len, exp_q[i].len);
      end
    end
    got_q.delete();
    exp_q.delete();
  endtask

  initial begin
    tbl[0]  = '{64,   KIND_T, 16,  4'b1111, 64,   1'b0};
    tbl[1]  = '{65,   KIND_T, 17,  4'b0001, 65,   1'b0};
    tbl[2]  = '{66,   KIND_T, 17,  4'b0011, 66,   1'b0};
    tbl[3]  = '{67,   KIND_T, 17,  4'b0111, 67,   1'b0};
    tbl[4]  = '{60,   KIND_T, 15,  4'b1111, 60,   1'b1};
    tbl[5]  = '{42,   KIND_E, 11,  4'b0011, 42,   1'b1};
    tbl[6]  = '{0,    KIND_E, 1,   4'b0000, 0,    1'b1};
    tbl[7]  = '{100,  KIND_C, 25,  4'b1111, 100,  1'b1};
    tbl[8]  = '{1522, KIND_T, 381, 4'b0011, 1522, 1'b0};
    tbl[9]  = '{1600, KIND_T, 381, 4'b1111, 1524, 1'b1};
    tbl[10] = '{68,   KIND_T, 17,  4'b1111, 68,   1'b0};

    // Reset with a start word on the inputs: outputs must stay cleared.
    i_reset  = 1'b1;
    i_clk_en = 1'b1;
    i_clr    = 1'b0;
    i_ctrl   = 4'b0001;
    i_data   = 32'h555555FB;
    repeat (3) @(posedge clk);
    #1;
    check("reset o_valid", int'(o_valid), 0);
    check("reset o_sof", int'(o_sof), 0);
    check("reset o_eof", int'(o_eof), 0);
    check("reset o_err", int'(o_err), 0);
    check("reset o_keep", int'(o_keep), 0);
    check("reset o_data", int'(o_data), 0);
    check("reset o_len", int'(o_len), 0);
    i_reset = 1'b0;
    i_ctrl  = 4'hF;
    i_data  = 32'h07070707;
    flush();

    for (int i = 0; i < 11; i++) begin
      send_frame(tbl[i].len, tbl[i].kind, 1, 1'b0);
      flush();
      check($sformatf("vec%0d words", i), got_q.size(), tbl[i].words);
      if (got_q.size() > 0) begin
        check($sformatf("vec%0d last keep", i), int'(got_q[$].keep), int'(tbl[i].keep));
        check($sformatf("vec%0d last eof", i), int'(got_q[$].eof), 1);
        check($sformatf("vec%0d last len", i), got_q[$].len, tbl[i].len_exp);
        check($sformatf("vec%0d last err", i), int'(got_q[$].err), int'(tbl[i].err));
      end
      compare_streams($sformatf("vec%0d", i));
    end

    // Bad SFD: the whole frame is ignored.
    send_frame(64, KIND_T, 1, 1'b1);
    flush();
    check("bad sfd no output", got_q.size(), 0);
    got_q.delete();

    // Back-to-back frames with /S/ straight after the terminator word.
    send_frame(70, KIND_T, 0, 1'b0);
    send_frame(64, KIND_T, 0, 1'b0);
    send_frame(72, KIND_T, 0, 1'b0);
    send_frame(65, KIND_T, 2, 1'b0);
    flush();
    compare_streams("b2b");

    // First-word latency, then a clear mid-frame drops the pending word.
    pay_q.delete();
    for (int i = 0; i < 20; i++) pay_q.push_back(8'($urandom));
    step(4'b0001, 32'h555555FB);
    step(4'b0000, 32'hD5555555);
    for (int w = 0; w < 5; w++) begin
      step(4'b0000, pay_word(w));
      if (w == 2) begin
        check("latency o_valid", int'(o_valid), 1);
        check("latency o_sof", int'(o_sof), 1);
        check("latency o_data", int'(o_data), int'(pay_word(0)));
      end
    end
    step(4'b0000, $urandom, 1'b1);
    @(posedge clk);
    #1;
    check("clear o_valid", int'(o_valid), 0);
    check("clear o_eof", int'(o_eof), 0);
    i_clr  = 1'b0;
    i_ctrl = 4'hF;
    i_data = 32'h07070707;
    for (int w = 0; w < 4; w++) begin
      exp_q.push_back('{pay_word(w), 4'hF, w == 0, 1'b0, 1'b0, 0});
    end
    send_frame(64, KIND_T, 1, 1'b0);
    flush();
    compare_streams("clear");

    // Clock enable toggling must not change the delivered word stream.
    toggle = 1'b1;
    for (int n = 0; n < 6; n++) begin
      send_frame($urandom_range(90, 0), $urandom_range(2, 0), $urandom_range(2, 0), 1'b0);
    end
    flush();
    toggle = 1'b0;
    compare_streams("clk_en");

    // Random frames, occasionally oversized.
    for (int n = 0; n < 16; n++) begin
      int kind, len;
      kind = $urandom_range(2, 0);
      if (kind == KIND_T && $urandom_range(7, 0) == 0) len = $urandom_range(1700, 1524);
      else len = $urandom_range(150, 0);
      send_frame(len, kind, $urandom_range(2, 0), 1'b0);
    end
    flush();
    compare_streams("random");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
